// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer with IDLE/RUN/HALTED run control.
// Define LINK_REG_EN to add a one-entry link register for Call/Ret.
module prog_ctr #(
    parameter int            D          = 12,
    parameter logic [D-1:0]  START_ADDR = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         AbsJump,
    input  logic [D-1:0] Target,
    input  logic         RelJump,
    input  logic [7:0]   Offset,
    input  logic         Halt,
    input  logic         Call,
    input  logic         Ret,
    output logic [D-1:0] ProgCtr,
    output logic         Running,
    output logic         Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t       state;
    logic [D-1:0] pc;

    // Displacement is sign-extended to the PC width; the sum wraps modulo 2^D.
    function automatic logic [D-1:0] add_offset(input logic [D-1:0] base,
                                                input logic signed [7:0] off);
        logic signed [D-1:0] ext;
        ext = {{(D-8){off[7]}}, off};
        return base + ext;
    endfunction

    function automatic logic [D-1:0] incr(input logic [D-1:0] base);
        return base + {{(D-1){1'b0}}, 1'b1};
    endfunction

`ifdef LINK_REG_EN
    logic [D-1:0] link;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc    <= '0;
            link  <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        pc    <= START_ADDR;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state <= HALTED;
                    end else if (Stall) begin
                        pc <= pc;
                    end else if (AbsJump) begin
                        pc <= Target;
                    end else if (Call) begin
                        link <= incr(pc);
                        pc   <= Target;
                    end else if (Ret) begin
                        pc <= link;
                    end else if (RelJump) begin
                        pc <= add_offset(pc, Offset);
                    end else begin
                        pc <= incr(pc);
                    end
                end
                HALTED: begin
                    if (Start) begin
                        pc    <= START_ADDR;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Without a link register Ret has no meaning and is deliberately dropped.
    logic unused_ret;
    assign unused_ret = Ret;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc    <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        pc    <= START_ADDR;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state <= HALTED;
                    end else if (Stall) begin
                        pc <= pc;
                    end else if (AbsJump || Call) begin
                        pc <= Target;
                    end else if (RelJump) begin
                        pc <= add_offset(pc, Offset);
                    end else begin
                        pc <= incr(pc);
                    end
                end
                HALTED: begin
                    if (Start) begin
                        pc    <= START_ADDR;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    assign ProgCtr = pc;
    assign Running = (state == RUN);
    assign Done    = (state == HALTED);

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: stimulus queues expected PC/Running/Done,
// a monitor pops and compares one entry after every rising edge.
module tb_prog_ctr;

    logic        clk = 1'b0;
    logic        rst, start, stall, abs_j, rel_j, halt, call, ret;
    logic [11:0] tgt;
    logic [7:0]  off;
    logic [11:0] pc;
    logic        running, done;

    typedef struct {
        string       name;
        logic [11:0] pc;
        logic        run;
        logic        dn;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_ctr #(.D(12), .START_ADDR(12'd0)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .Stall(stall),
        .AbsJump(abs_j), .Target(tgt), .RelJump(rel_j), .Offset(off),
        .Halt(halt), .Call(call), .Ret(ret),
        .ProgCtr(pc), .Running(running), .Done(done)
    );

    always #5 clk = ~clk;

    task automatic clr();
        rst = 0; start = 0; stall = 0; abs_j = 0; rel_j = 0;
        halt = 0; call = 0; ret = 0; tgt = '0; off = '0;
    endtask

    // Inputs are already set by the caller; queue the post-edge expectation.
    task automatic tick(input string nm, input logic [11:0] p,
                        input logic r, input logic d);
        exp_t e;
        e.name = nm; e.pc = p; e.run = r; e.dn = d;
        q.push_back(e);
        @(negedge clk);
        clr();
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (pc !== e.pc || running !== e.run || done !== e.dn) begin
                n_fail++;
                $display("FAIL %s: got pc=%0d run=%b done=%b, want pc=%0d run=%b done=%b",
                         e.name, pc, running, done, e.pc, e.run, e.dn);
            end
        end
    end

    initial begin
        clr();
        rst = 1; tick("reset0", 0, 0, 0);
        rst = 1; tick("reset1", 0, 0, 0);
        tick("idle_hold", 0, 0, 0);
        start = 1; tick("start", 0, 1, 0);
        for (int i = 1; i <= 10; i++) tick("incr", 12'(i), 1, 0);

        abs_j = 1; tgt = 12'd17; rel_j = 1; off = 8'd3;
        tick("abs_over_rel", 17, 1, 0);
        rel_j = 1; off = 8'hFB; tick("rel_neg", 12, 1, 0);
        start = 1; tick("start_in_run", 13, 1, 0);

        abs_j = 1; tgt = 12'd4095; tick("abs_max", 4095, 1, 0);
        for (int i = 0; i < 3; i++) begin
            stall = 1; tick("stall", 4095, 1, 0);
        end
        tick("wrap", 0, 1, 0);
        stall = 1; abs_j = 1; tgt = 12'd5; tick("stall_over_abs", 0, 1, 0);
        tick("incr_after_stall", 1, 1, 0);
        tick("incr2", 2, 1, 0);
        rel_j = 1; off = 8'hFB; tick("rel_wrap", 4093, 1, 0);

        abs_j = 1; tgt = 12'd30; tick("abs30", 30, 1, 0);
        halt = 1; abs_j = 1; tgt = 12'd53; tick("halt_over_abs", 30, 0, 1);
        abs_j = 1; tgt = 12'd7; tick("halted_ign_abs", 30, 0, 1);
        halt = 1; stall = 1; rel_j = 1; off = 8'd4; tick("halted_ign_misc", 30, 0, 1);
        start = 1; tick("restart", 0, 1, 0);

        abs_j = 1; tgt = 12'd75; tick("abs75", 75, 1, 0);
        rst = 1; start = 1; abs_j = 1; tgt = 12'd9; tick("mid_reset", 0, 0, 0);
        abs_j = 1; tgt = 12'd9; tick("idle_ign_abs", 0, 0, 0);
        tick("idle_hold2", 0, 0, 0);
        start = 1; tick("start2", 0, 1, 0);
        tick("incr_after_start", 1, 1, 0);

        abs_j = 1; tgt = 12'd20; tick("abs20", 20, 1, 0);
        call = 1; tgt = 12'd84; tick("call", 84, 1, 0);
`ifdef LINK_REG_EN
        ret = 1; tick("ret", 21, 1, 0);
        call = 1; ret = 1; tgt = 12'd40; tick("call_over_ret", 40, 1, 0);
        stall = 1; ret = 1; tick("stall_blocks_ret", 40, 1, 0);
        ret = 1; tick("ret2", 41, 1, 0);
`else
        ret = 1; tick("ret_ignored", 85, 1, 0);
        call = 1; ret = 1; tgt = 12'd40; tick("call_as_abs", 40, 1, 0);
        stall = 1; ret = 1; tick("stall_with_ret", 40, 1, 0);
        ret = 1; tick("ret_ignored2", 41, 1, 0);
`endif
        abs_j = 1; tgt = 12'd0; tick("target_zero", 0, 1, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
Name: prog_ctr

Overview:
- Program counter and fetch sequencer for the single-cycle core.
- Holds the current instruction address and drives instruction memory each cycle.
- Its next value comes from one of: sequential increment, an absolute jump to the 12-bit target produced by the jump-target lookup stage, or a PC-relative branch.
- Also owns the start/halt run control that the top-level testbench handshakes with.

Parameters:
- D, 12, PC width in bits; matches the jump-target lookup output width.
- START_ADDR, 0, PC value loaded on Start.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; begins or restarts a program from START_ADDR.
- Stall  input  1  hold the PC this cycle.
- AbsJump  input  1  load Target into the PC.
- Target  input  D  absolute jump address from the jump-target lookup stage.
- RelJump  input  1  branch taken; add Offset to the PC.
- Offset  input  8  signed two's-complement branch displacement.
- Halt  input  1  decoded halt instruction at the current PC.
- Call  input  1  subroutine call; see Optional Feature.
- Ret  input  1  subroutine return; see Optional Feature.
- ProgCtr  output  D  current instruction address.
- Running  output  1  high in the RUN state.
- Done  output  1  high in the HALTED state; acknowledges program completion.

Behaviour:
- States are IDLE, RUN and HALTED. Running and Done are decoded from the registered state, so they have no combinational path from the inputs.
- Reset (sync), at the next edge:
  - ProgCtr = 0, state = IDLE, Running = 0, Done = 0, link register = 0.
  - Reset overrides every other input.
- IDLE:
  - ProgCtr holds.
  - Start = 1 -> ProgCtr <= START_ADDR, go to RUN.
  - All other inputs are ignored.
- RUN: next-PC priority, highest first:
  1. Halt -> ProgCtr holds, go to HALTED.
  2. Stall -> ProgCtr holds.
  3. AbsJump -> ProgCtr <= Target.
  4. Call / Ret (only when LINK_REG_EN is defined).
  5. RelJump -> ProgCtr <= ProgCtr + sign_extend(Offset).
  6. Otherwise -> ProgCtr <= ProgCtr + 1.
- Start during RUN is ignored and does not restart the program.
- Latency: exactly 1 cycle. The selected next address appears on ProgCtr on the edge after the request is sampled. There is no combinational path from any input to ProgCtr.
- Arithmetic: all PC math is modulo 2^D.
  - Incrementing from 2^D-1 wraps to 0.
  - Offset is sign-extended to D bits. With PC = 2 and Offset = -5 (8'hFB), the result is 2^D-3 = 4093.
- Simultaneous AbsJump and RelJump: AbsJump wins.
- Halt together with any jump: Halt wins, and the PC does not change.
- HALTED:
  - ProgCtr holds, Done = 1.
  - Start = 1 -> ProgCtr <= START_ADDR, Done falls on the same edge, go to RUN.
  - Halt, Stall and jumps are ignored.
- Target handling: Target is used unmodified. A lookup value of 0 restarts at address 0. No range check is applied.

Optional Feature:
- Macro: LINK_REG_EN.
- Defined:
  - Adds a one-entry link register, reset to 0.
  - Call in RUN (below AbsJump, above RelJump): link <= ProgCtr + 1 (mod 2^D) and ProgCtr <= Target on the same edge.
  - Ret: ProgCtr <= link, and link is unchanged.
  - Call and Ret asserted together: Call wins.
  - Stall or Halt blocks both Call and Ret; the link register is unchanged.
- Not defined:
  - No link register.
  - Call behaves exactly as AbsJump (ProgCtr <= Target).
  - Ret is ignored, and the PC increments normally unless another request applies.

Test Plan:
- Reset then Start: Reset for 2 cycles, then pulse Start -> ProgCtr = 0 and Running = 1 one cycle later. Five idle cycles then give ProgCtr = 1, 2, 3, 4, 5.
- Jump priority: at PC = 10, drive AbsJump = 1, Target = 17, RelJump = 1, Offset = 3 in the same cycle -> ProgCtr = 17. Next cycle, RelJump with Offset = -5 -> ProgCtr = 12.
- Stall and wrap: force PC to 4095 via AbsJump with Target = 4095. Stall for 3 cycles -> ProgCtr stays 4095. Release -> ProgCtr = 0.
- Halt and restart: Halt at PC = 30 together with AbsJump to 53 -> ProgCtr stays 30, Done = 1, Running = 0. A later Start -> ProgCtr = 0, Done = 0.
- Mid-run reset: Reset asserted while RUN at PC = 75 -> next edge gives ProgCtr = 0, state IDLE. Start is required before the PC advances again.
- LINK_REG_EN call/return:
  - Defined: Call at PC = 20 with Target = 84 -> PC = 84, link = 21. Then Ret -> PC = 21.
  - Not defined: the same Call gives PC = 84, and Ret then gives PC = 85.
